// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : dm_arb_pkg
// Brief  : Shared types and defaults for the data-memory arbiter. It holds the
//          arbiter state encoding and the default starvation limit and
//          counter width.
// Revision: 1.0 - initial release
// ============================================================================
package dm_arb_pkg;

    // Arbiter states. The pipeline owns the data memory in ST_IDLE and in
    // ST_ACK. The external port owns it in ST_XGNT.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XGNT = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_e;

    localparam int c_STARVE_LIMIT_DEFAULT = 4;
    localparam int c_CNT_W_DEFAULT        = 4;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that saturates at a run-time limit and can be cleared
//          synchronously.
// Ports  : clk, rst        - clock and synchronous active-high reset
//          inc             - count up by one (ignored once the limit is reached)
//          clr             - clear to zero (takes priority over inc)
//          limit[CNT_W]    - saturation value
//          count[CNT_W]    - current count
//          at_limit        - count equals limit
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && !at_limit) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q == limit);

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dm_arbiter
// Brief  : Shares one data-memory port between the pipeline M stage and an
//          external request/ack port. The pipeline normally owns the memory.
//          An external request takes one XGNT cycle, which stalls the M stage
//          if it is accessing memory. An ACK cycle follows it. A starvation
//          counter forces the external request through after STARVE_LIMIT
//          lost IDLE cycles.
// Ports  : clk, reset                     - clock, synchronous active-high reset
//          m_req/m_we/m_addr/m_wdata/m_pc - M-stage memory access
//          x_req/x_we/x_addr/x_wdata      - external request, held until x_ack
//          dm_rdata                       - combinational DM read data
//          dm_addr/dm_wdata/dm_we/dm_pc   - DM access port
//          m_stall                        - freeze the pipeline up to M
//          x_ack/x_rdata/x_err            - registered external completion
// Revision: 1.0 - initial release
// ============================================================================
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = c_STARVE_LIMIT_DEFAULT,
    parameter int CNT_W        = c_CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [31:0] m_pc,
    input  logic        x_req,
    input  logic        x_we,
    input  logic [31:0] x_addr,
    input  logic [31:0] x_wdata,
    input  logic [31:0] dm_rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_we,
    output logic [31:0] dm_pc,
    output logic        m_stall,
    output logic        x_ack,
    output logic [31:0] x_rdata,
    output logic        x_err
);

    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q;
    logic             x_ack_q;
    logic             x_err_q;
    logic [31:0]      x_rdata_q;

    logic             w_idle;
    logic             w_grant;
    logic             w_starve_inc;
    logic             w_at_limit;
    logic             w_x_misaligned;
    logic [CNT_W-1:0] w_starve_cnt;

    assign w_idle         = (state_q == ST_IDLE);
    assign w_x_misaligned = (x_addr[1:0] != 2'b00);

    // The external port wins when the pipeline is not using memory, or when
    // it has already lost STARVE_LIMIT times.
    assign w_grant = w_idle && x_req && (!m_req || (w_starve_cnt == c_LIMIT));

    // With m_req high, the only way a request is refused is that the counter
    // has not reached the limit yet, so this is exactly "lost this cycle".
    assign w_starve_inc = w_idle && x_req && m_req && !w_at_limit;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_starve (
        .clk      (clk),
        .rst      (reset),
        .inc      (w_starve_inc),
        .clr      (w_grant),
        .limit    (c_LIMIT),
        .count    (w_starve_cnt),
        .at_limit (w_at_limit)
    );

    // DM port mux. Reset suppresses any write, so a transaction aborted in
    // XGNT leaves memory untouched.
    always_comb begin
        dm_addr  = m_addr;
        dm_wdata = m_wdata;
        dm_we    = m_we & m_req;
        dm_pc    = m_pc;
        m_stall  = 1'b0;
        if (state_q == ST_XGNT) begin
            dm_addr  = x_addr;
            dm_wdata = x_wdata;
            dm_we    = x_we & ~w_x_misaligned;
            dm_pc    = 32'h0;
            m_stall  = m_req;
        end
        if (reset) begin
            dm_we   = 1'b0;
            m_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            x_ack_q   <= 1'b0;
            x_err_q   <= 1'b0;
            x_rdata_q <= 32'h0;
        end else begin
            x_ack_q <= 1'b0;
            x_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_grant) begin
                        state_q <= ST_XGNT;
                    end
                end
                ST_XGNT: begin
                    state_q   <= ST_ACK;
                    x_ack_q   <= 1'b1;
                    x_err_q   <= w_x_misaligned;
                    x_rdata_q <= dm_rdata;
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign x_ack   = x_ack_q;
    assign x_err   = x_err_q;
    assign x_rdata = x_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dm_arbiter
// Brief  : Self-checking bench for dm_arbiter. It runs directed scenarios and
//          then random traffic. The random traffic is checked against a
//          transaction-level reference: external requests win or lose by the
//          starvation rule, stalled pipeline accesses are re-presented, and a
//          reference memory image is compared with the DM model at the end.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_req, m_we, x_req, x_we;
    logic [31:0] m_addr, m_wdata, m_pc, x_addr, x_wdata;
    logic [31:0] dm_rdata, dm_addr, dm_wdata, dm_pc, x_rdata;
    logic        dm_we, m_stall, x_ack, x_err;

    always #5 clk = ~clk;

    dm_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_pc(m_pc),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
        .dm_rdata(dm_rdata), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
        .dm_pc(dm_pc), .m_stall(m_stall), .x_ack(x_ack), .x_rdata(x_rdata), .x_err(x_err)
    );

    // Data memory model: combinational read, write on the rising edge.
    logic [31:0] mem [0:63] = '{default: 32'h0};
    int          wr_count = 0;
    assign dm_rdata = mem[dm_addr[7:2]];
    always @(posedge clk) begin
        if (dm_we) begin
            mem[dm_addr[7:2]] <= dm_wdata;
            wr_count          <= wr_count + 1;
        end
    end

    logic [31:0] ref_mem [0:63] = '{default: 32'h0};
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pipeline reads 0x40 continuously while the external port reads addr.
    // The request must lose LIM IDLE cycles and win on the next one.
    task automatic starve_read(input logic [31:0] addr, input logic [31:0] exp);
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h40; m_pc = 32'h100;
        x_req = 1'b1; x_we = 1'b0; x_addr = addr;
        #1;
        for (int i = 0; i <= LIM; i++) begin
            check("starve_idle_owner", dm_addr, 32'h40);
            check("starve_idle_stall", 32'(m_stall), 32'd0);
            cyc();
        end
        check("starve_xgnt_stall", 32'(m_stall), 32'd1);
        check("starve_xgnt_addr", dm_addr, addr);
        cyc();
        check("starve_ack", 32'(x_ack), 32'd1);
        check("starve_rdata", x_rdata, exp);
        check("starve_ack_stall", 32'(m_stall), 32'd0);
        x_req = 1'b0; m_req = 1'b0;
        cyc();
        check("starve_ack_pulse", 32'(x_ack), 32'd0);
    endtask

    int          ph, gap, losses, n0;
    logic        hold, exp_err;
    logic [31:0] exp_rdata;

    initial begin
        reset = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_pc = '0;
        x_req = 1'b0; x_we = 1'b0; x_addr = '0; x_wdata = '0;
        cyc();
        // Reset gating of the DM write and of the stall.
        m_req = 1'b1; m_we = 1'b1; x_req = 1'b1;
        #1;
        check("rst_dm_we", 32'(dm_we), 32'd0);
        check("rst_m_stall", 32'(m_stall), 32'd0);
        cyc(); cyc();
        m_req = 1'b0; m_we = 1'b0; x_req = 1'b0; reset = 1'b0;
        #1;
        check("rst_x_ack", 32'(x_ack), 32'd0);
        check("rst_x_err", 32'(x_err), 32'd0);
        check("rst_x_rdata", x_rdata, 32'd0);

        // An external write with an idle pipeline is granted immediately.
        x_req = 1'b1; x_we = 1'b1; x_addr = 32'h10; x_wdata = 32'hDEADBEEF;
        #1;
        check("t1_idle_ack", 32'(x_ack), 32'd0);
        cyc();
        check("t1_xgnt_we", 32'(dm_we), 32'd1);
        check("t1_xgnt_addr", dm_addr, 32'h10);
        check("t1_xgnt_pc", dm_pc, 32'h0);
        check("t1_xgnt_stall", 32'(m_stall), 32'd0);
        ref_mem[4] = 32'hDEADBEEF;
        cyc();
        check("t1_ack", 32'(x_ack), 32'd1);
        check("t1_err", 32'(x_err), 32'd0);
        x_req = 1'b0;
        cyc();
        check("t1_ack_pulse", 32'(x_ack), 32'd0);
        check("t1_mem", mem[4], 32'hDEADBEEF);

        // Starved read of the value just written.
        starve_read(32'h10, 32'hDEADBEEF);

        // A misaligned write is suppressed and flagged.
        x_req = 1'b1; x_we = 1'b1; x_addr = 32'h13; x_wdata = 32'h12345678;
        #1;
        cyc();
        check("t3_xgnt_we", 32'(dm_we), 32'd0);
        cyc();
        check("t3_ack", 32'(x_ack), 32'd1);
        check("t3_err", 32'(x_err), 32'd1);
        x_req = 1'b0;
        cyc();
        check("t3_mem", mem[4], 32'hDEADBEEF);
        check("t3_err_pulse", 32'(x_err), 32'd0);

        // A store stalled in XGNT is written exactly once, in ACK.
        x_req = 1'b1; x_we = 1'b0; x_addr = 32'h30;
        #1;
        cyc();
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h20; m_wdata = 32'h55; m_pc = 32'h200;
        #1;
        check("t4_xgnt_stall", 32'(m_stall), 32'd1);
        check("t4_xgnt_we", 32'(dm_we), 32'd0);
        n0 = wr_count;
        cyc();
        check("t4_ack_stall", 32'(m_stall), 32'd0);
        check("t4_ack_we", 32'(dm_we), 32'd1);
        check("t4_ack_pc", dm_pc, 32'h200);
        check("t4_ack_addr", dm_addr, 32'h20);
        ref_mem[8] = 32'h55;
        x_req = 1'b0;
        cyc();
        m_req = 1'b0; m_we = 1'b0;
        #1;
        check("t4_mem", mem[8], 32'h55);
        check("t4_once", 32'(wr_count - n0), 32'd1);

        // Reset in XGNT aborts the write and the ack.
        x_req = 1'b1; x_we = 1'b1; x_addr = 32'h24; x_wdata = 32'h00000BAD;
        #1;
        cyc();
        reset = 1'b1; m_req = 1'b1;
        #1;
        check("t5_rst_we", 32'(dm_we), 32'd0);
        check("t5_rst_stall", 32'(m_stall), 32'd0);
        cyc();
        reset = 1'b0; x_req = 1'b0; m_req = 1'b0;
        #1;
        check("t5_no_ack", 32'(x_ack), 32'd0);
        check("t5_rdata_clr", x_rdata, 32'h0);
        cyc();
        check("t5_no_ack2", 32'(x_ack), 32'd0);
        check("t5_mem", mem[9], 32'h0);
        starve_read(32'h10, 32'hDEADBEEF);

        // A held request gives an ack every third cycle.
        x_req = 1'b1; x_we = 1'b0; x_addr = 32'h10;
        #1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) cyc();
            check("t6_b2b_ack", 32'(x_ack), ((k % 3) == 2) ? 32'd1 : 32'd0);
            if ((k % 3) == 2) check("t6_b2b_rdata", x_rdata, 32'hDEADBEEF);
        end
        x_req = 1'b0;
        cyc();

        // Random traffic against the transaction-level reference.
        ph = 0; gap = 0; hold = 1'b0; losses = 0;
        for (int c = 0; c < 700 && (c < 600 || ph != 0); c++) begin
            cyc();
            if (!hold) begin
                m_req   = 1'($urandom_range(0, 1));
                m_we    = 1'($urandom_range(0, 1));
                m_addr  = 32'(32 + $urandom_range(0, 15)) << 2;
                m_wdata = $urandom;
                m_pc    = $urandom | 32'h1;
            end
            if (ph == 0) begin
                if (gap == 0) begin
                    ph = 1; losses = 0; x_req = 1'b1;
                    x_we    = 1'($urandom_range(0, 1));
                    x_addr  = 32'($urandom_range(0, 15)) << 2;
                    if ($urandom_range(0, 3) == 0) x_addr[1:0] = 2'($urandom_range(1, 3));
                    x_wdata = $urandom;
                end else begin
                    gap--;
                end
            end
            #1;
            case (ph)
                1: begin
                    check("r_wait_ack", 32'(x_ack), 32'd0);
                    check("r_wait_stall", 32'(m_stall), 32'd0);
                    check("r_wait_addr", dm_addr, m_addr);
                    check("r_wait_we", 32'(dm_we), 32'(m_req & m_we));
                    if (!m_req || losses == LIM) ph = 2;
                    else losses++;
                    if (m_req && m_we) ref_mem[m_addr[7:2]] = m_wdata;
                    hold = 1'b0;
                end
                2: begin
                    check("r_xgnt_stall", 32'(m_stall), 32'(m_req));
                    check("r_xgnt_addr", dm_addr, x_addr);
                    check("r_xgnt_we", 32'(dm_we), 32'(x_we && x_addr[1:0] == 2'b00));
                    check("r_xgnt_pc", dm_pc, 32'h0);
                    exp_rdata = ref_mem[x_addr[7:2]];
                    exp_err   = (x_addr[1:0] != 2'b00);
                    if (x_we && !exp_err) ref_mem[x_addr[7:2]] = x_wdata;
                    hold = m_req;
                    ph = 3;
                end
                3: begin
                    check("r_ack", 32'(x_ack), 32'd1);
                    check("r_ack_err", 32'(x_err), 32'(exp_err));
                    check("r_ack_rdata", x_rdata, exp_rdata);
                    check("r_ack_stall", 32'(m_stall), 32'd0);
                    check("r_ack_we", 32'(dm_we), 32'(m_req & m_we));
                    if (m_req && m_we) ref_mem[m_addr[7:2]] = m_wdata;
                    hold = 1'b0; x_req = 1'b0; ph = 0;
                    gap = $urandom_range(0, 2);
                end
                default: begin
                    check("r_gap_ack", 32'(x_ack), 32'd0);
                    check("r_gap_stall", 32'(m_stall), 32'd0);
                    check("r_gap_we", 32'(dm_we), 32'(m_req & m_we));
                    if (m_req && m_we) ref_mem[m_addr[7:2]] = m_wdata;
                    hold = 1'b0;
                end
            endcase
        end
        cyc();
        m_req = 1'b0; m_we = 1'b0; x_req = 1'b0;
        cyc();
        for (int i = 0; i < 64; i++) begin
            check($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
